mem_access_stage: RTL and testbench

Memory-access (MEM) pipeline stage of the RV32IC core. It sits directly downstream of the ALU/EX stage and consumes the EX→MEM hand-off: ALU result/address, store data, func3, destination register and control bits. It performs load/store alignment, byte-enable generation and load sign/zero extension, and runs a req/ack handshake with the data memory. It registers one writeback record per accepted operation and stalls the upstream stage while a memory access is outstanding.

---
 rtl/mem_access_stage_if.sv | 39 +++
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// EX->MEM hand-off, data-memory port and writeback record of the MEM stage.
// The slave modport is the stage's view of the bundle; the master modport is the environment's view.
interface mem_access_stage_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_alu_out;
    logic [31:0] i_rd2;
    logic [2:0]  i_func3;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic        o_wb_reg_write;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_exc;

    modport slave (
        input  i_valid, i_alu_out, i_rd2, i_func3, i_mem_read, i_mem_write, i_rd, i_reg_write,
        input  i_dmem_ack, i_dmem_rdata,
        output o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        output o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_exc
    );

    modport master (
        output i_valid, i_alu_out, i_rd2, i_func3, i_mem_read, i_mem_write, i_rd, i_reg_write,
        output i_dmem_ack, i_dmem_rdata,
        input  o_ready, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        input  o_wb_valid, o_wb_reg_write, o_wb_rd, o_wb_data, o_exc
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: load/store alignment, byte enables, load extension and a
// req/ack data-memory handshake with a bus timeout; one registered writeback per op.
module mem_access_stage #(
    parameter logic [7:0] DMEM_TIMEOUT = 8'd255
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    mem_access_stage_if.slave     bus
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  off_q, off_d;
    logic        rw_q, rw_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_rw_q, wb_rw_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_q, exc_d;
    logic        legal_s, misaligned_s, op_exc_s, timeout_s;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  store_be = 4'b0001 << off;
            3'b001:  store_be = 4'b0011 << off;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rd2);
        case (f3)
            3'b000:  store_wdata = {4{rd2[7:0]}};
            3'b001:  store_wdata = {2{rd2[15:0]}};
            default: store_wdata = rd2;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = rdata >> {off, 3'b000};
        half    = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extract = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_extract = {{16{half[15]}}, half};
            3'b100:  load_extract = {24'd0, shifted[7:0]};
            3'b101:  load_extract = {16'd0, half};
            default: load_extract = rdata;
        endcase
    endfunction

    // Width legality and alignment of the op presented on the EX->MEM inputs.
    always_comb begin
        legal_s      = 1'b0;
        misaligned_s = 1'b0;
        case (bus.i_func3)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = bus.i_mem_read;
            default:                legal_s = 1'b0;
        endcase
        case (bus.i_func3[1:0])
            2'b01:   misaligned_s = bus.i_alu_out[0];
            2'b10:   misaligned_s = (bus.i_alu_out[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        op_exc_s  = (bus.i_mem_read & bus.i_mem_write) | ~legal_s | misaligned_s;
        // cnt_q counts completed wait cycles, so the limit is hit on the DMEM_TIMEOUT-th req cycle.
        timeout_s = (DMEM_TIMEOUT != 8'd0) && (({1'b0, cnt_q} + 9'd1) == {1'b0, DMEM_TIMEOUT});
    end

    // Next-state and writeback record selection.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        func3_d    = func3_q;
        off_d      = off_q;
        rw_d       = rw_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        exc_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    wb_rd_d = bus.i_rd;
                    if (!bus.i_mem_read && !bus.i_mem_write) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.i_alu_out;
                        wb_rw_d    = bus.i_reg_write;
                    end else if (op_exc_s) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = 32'd0;
                        exc_d      = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        addr_d  = {bus.i_alu_out[31:2], 2'b00};
                        off_d   = bus.i_alu_out[1:0];
                        we_d    = bus.i_mem_write;
                        func3_d = bus.i_func3;
                        rw_d    = bus.i_reg_write;
                        cnt_d   = 8'd0;
                        be_d    = bus.i_mem_write ? store_be(bus.i_func3, bus.i_alu_out[1:0]) : 4'b1111;
                        wdata_d = bus.i_mem_write ? store_wdata(bus.i_func3, bus.i_rd2) : 32'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (bus.i_dmem_ack) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    if (we_q) begin
                        wb_data_d = 32'd0;
                    end else begin
                        wb_data_d = load_extract(func3_q, off_q, bus.i_dmem_rdata);
                        wb_rw_d   = rw_q;
                    end
                end else if (timeout_s) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = 32'd0;
                    exc_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight access.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            we_q       <= 1'b0;
            func3_q    <= 3'd0;
            off_q      <= 2'd0;
            rw_q       <= 1'b0;
            cnt_q      <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            func3_q    <= func3_d;
            off_q      <= off_d;
            rw_q       <= rw_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            exc_q      <= exc_d;
        end
    end

    assign bus.o_ready        = (state_q == S_IDLE);
    assign bus.o_dmem_req     = (state_q == S_ACCESS);
    assign bus.o_dmem_we      = we_q;
    assign bus.o_dmem_addr    = addr_q;
    assign bus.o_dmem_wdata   = wdata_q;
    assign bus.o_dmem_be      = be_q;
    assign bus.o_wb_valid     = wb_valid_q;
    assign bus.o_wb_reg_write = wb_rw_q;
    assign bus.o_wb_rd        = wb_rd_q;
    assign bus.o_wb_data      = wb_data_q;
    assign bus.o_exc          = exc_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writeback records are queued
// at issue and compared by a monitor whenever o_wb_valid pulses.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;

    always #5 clk = ~clk;

    mem_access_stage_if bus_if();
    mem_access_stage #(.DMEM_TIMEOUT(8'd4)) dut (.i_clk(clk), .i_reset(rst), .bus(bus_if));

    // Scoreboard monitor: every writeback pulse must match the oldest queued record.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.o_wb_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected got rd=%0d data=%h exc=%b, expected no writeback",
                             bus_if.o_wb_rd, bus_if.o_wb_data, bus_if.o_exc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({bus_if.o_wb_reg_write, bus_if.o_wb_rd, bus_if.o_wb_data, bus_if.o_exc} !==
                        {mon_e.rw, mon_e.rd, mon_e.data, mon_e.exc}) begin
                        failures++;
                        $display("FAIL wb_record got rw=%b rd=%0d data=%h exc=%b, expected rw=%b rd=%0d data=%h exc=%b",
                                 bus_if.o_wb_reg_write, bus_if.o_wb_rd, bus_if.o_wb_data, bus_if.o_exc,
                                 mon_e.rw, mon_e.rd, mon_e.data, mon_e.exc);
                    end
                end
            end else begin
                checks++;
                if (bus_if.o_exc !== 1'b0) begin
                    failures++;
                    $display("FAIL exc_without_wb got exc=%b, expected 0", bus_if.o_exc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic drive_idle();
        bus_if.i_valid      = 1'b0;
        bus_if.i_alu_out    = 32'd0;
        bus_if.i_rd2        = 32'd0;
        bus_if.i_func3      = 3'd0;
        bus_if.i_mem_read   = 1'b0;
        bus_if.i_mem_write  = 1'b0;
        bus_if.i_rd         = 5'd0;
        bus_if.i_reg_write  = 1'b0;
    endtask

    task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rd2,
                            input logic [4:0] rd, input logic rw);
        bus_if.i_valid      = 1'b1;
        bus_if.i_mem_read   = rd_en;
        bus_if.i_mem_write  = wr_en;
        bus_if.i_func3      = f3;
        bus_if.i_alu_out    = addr;
        bus_if.i_rd2        = rd2;
        bus_if.i_rd         = rd;
        bus_if.i_reg_write  = rw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus_if.i_dmem_ack   = 1'b0;
        bus_if.i_dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_if.o_ready, bus_if.o_dmem_req, bus_if.o_wb_valid, bus_if.o_exc, bus_if.o_dmem_be} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b req=%b wbv=%b exc=%b be=%b, expected 1 0 0 0 0000",
                     bus_if.o_ready, bus_if.o_dmem_req, bus_if.o_wb_valid, bus_if.o_exc, bus_if.o_dmem_be);
        end
        checks++;
        if ({bus_if.o_wb_data, bus_if.o_dmem_addr, bus_if.o_wb_rd} !== 69'd0) begin
            failures++;
            $display("FAIL reset_data got wb_data=%h addr=%h rd=%0d, expected zeros",
                     bus_if.o_wb_data, bus_if.o_dmem_addr, bus_if.o_wb_rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_stream();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus_if.o_wb_valid !== 1'b1 || bus_if.o_dmem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL alu_stream_%0d got wbv=%b req=%b, expected 1 0", i, bus_if.o_wb_valid, bus_if.o_dmem_req);
                end
            end
            drive_op(1'b0, 1'b0, 3'b000, 32'h11 * (i + 1), 32'hDEAD_BEEF, 5'(i + 1), 1'b1);
            sb_q.push_back('{rw: 1'b1, rd: 5'(i + 1), data: 32'h11 * (i + 1), exc: 1'b0});
        end
        @(negedge clk);
        checks++;
        if (bus_if.o_wb_valid !== 1'b1 || bus_if.o_dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_stream_3 got wbv=%b req=%b, expected 1 0", bus_if.o_wb_valid, bus_if.o_dmem_req);
        end
        drive_idle();
        @(negedge clk);
        checks++;
        if (bus_if.o_wb_valid !== 1'b0 || bus_if.o_dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL alu_stream_end got wbv=%b req=%b, expected 0 0", bus_if.o_wb_valid, bus_if.o_dmem_req);
        end
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        drive_op(1'b0, 1'b1, 3'b000, 32'h0000_1002, 32'hA5A5_12FF, 5'd5, 1'b1);
        sb_q.push_back('{rw: 1'b0, rd: 5'd5, data: 32'd0, exc: 1'b0});
        @(negedge clk);
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus_if.o_dmem_req, bus_if.o_dmem_we, bus_if.o_ready, bus_if.o_dmem_be} !== 7'b110_0100 ||
                bus_if.o_dmem_addr !== 32'h0000_1000 || bus_if.o_dmem_wdata !== 32'hFFFF_FFFF) begin
                failures++;
                $display("FAIL sb_bus_c%0d got req=%b we=%b ready=%b be=%b addr=%h wdata=%h, expected 1 1 0 0100 00001000 ffffffff",
                         c, bus_if.o_dmem_req, bus_if.o_dmem_we, bus_if.o_ready, bus_if.o_dmem_be,
                         bus_if.o_dmem_addr, bus_if.o_dmem_wdata);
            end
            if (c == 2) bus_if.i_dmem_ack = 1'b1;
            @(negedge clk);
        end
        bus_if.i_dmem_ack = 1'b0;
        checks++;
        if ({bus_if.o_wb_valid, bus_if.o_ready, bus_if.o_dmem_req} !== 3'b110) begin
            failures++;
            $display("FAIL sb_done got wbv=%b ready=%b req=%b, expected 1 1 0",
                     bus_if.o_wb_valid, bus_if.o_ready, bus_if.o_dmem_req);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [4] = '{3'b000, 3'b000, 3'b101, 3'b001};
        logic [1:0]  offs [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
        logic [31:0] exps [4] = '{32'h0000_007F, 32'hFFFF_FFF0, 32'h0000_8001, 32'hFFFF_8001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_op(1'b1, 1'b0, f3s[i], {30'h0000_0800, offs[i]}, 32'd0, 5'(10 + i), 1'b1);
            sb_q.push_back('{rw: 1'b1, rd: 5'(10 + i), data: exps[i], exc: 1'b0});
            @(negedge clk);
            drive_idle();
            checks++;
            if ({bus_if.o_dmem_req, bus_if.o_dmem_we, bus_if.o_dmem_be} !== 6'b10_1111 ||
                bus_if.o_dmem_addr !== 32'h0000_2000 || bus_if.o_wb_valid !== 1'b0) begin
                failures++;
                $display("FAIL load_bus_%0d got req=%b we=%b be=%b addr=%h wbv=%b, expected 1 0 1111 00002000 0",
                         i, bus_if.o_dmem_req, bus_if.o_dmem_we, bus_if.o_dmem_be, bus_if.o_dmem_addr, bus_if.o_wb_valid);
            end
            bus_if.i_dmem_ack   = 1'b1;
            bus_if.i_dmem_rdata = 32'h8001_F07F;
            @(negedge clk);
            bus_if.i_dmem_ack   = 1'b0;
            bus_if.i_dmem_rdata = 32'd0;
            checks++;
            if (bus_if.o_wb_valid !== 1'b1 || bus_if.o_ready !== 1'b1) begin
                failures++;
                $display("FAIL load_latency_%0d got wbv=%b ready=%b, expected 1 1", i, bus_if.o_wb_valid, bus_if.o_ready);
            end
        end
    endtask

    task automatic test_exceptions();
        logic        rds [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] ads [4] = '{32'h0000_1001, 32'h0000_1003, 32'h0000_1000, 32'h0000_1000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_op(rds[i], wrs[i], f3s[i], ads[i], 32'h1234_5678, 5'(20 + i), 1'b1);
            sb_q.push_back('{rw: 1'b0, rd: 5'(20 + i), data: 32'd0, exc: 1'b1});
            @(negedge clk);
            drive_idle();
            checks++;
            if ({bus_if.o_dmem_req, bus_if.o_wb_valid, bus_if.o_exc, bus_if.o_ready} !== 4'b0111) begin
                failures++;
                $display("FAIL exc_case_%0d got req=%b wbv=%b exc=%b ready=%b, expected 0 1 1 1",
                         i, bus_if.o_dmem_req, bus_if.o_wb_valid, bus_if.o_exc, bus_if.o_ready);
            end
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 5'd7, 1'b1);
        sb_q.push_back('{rw: 1'b0, rd: 5'd7, data: 32'd0, exc: 1'b1});
        @(negedge clk);
        drive_idle();
        while (bus_if.o_dmem_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL timeout_req_cycles got %0d, expected 4", n);
        end
        checks++;
        if ({bus_if.o_wb_valid, bus_if.o_exc, bus_if.o_ready} !== 3'b111) begin
            failures++;
            $display("FAIL timeout_exc got wbv=%b exc=%b ready=%b, expected 1 1 1",
                     bus_if.o_wb_valid, bus_if.o_exc, bus_if.o_ready);
        end
        drive_op(1'b0, 1'b0, 3'b000, 32'h0000_0099, 32'd0, 5'd9, 1'b1);
        sb_q.push_back('{rw: 1'b1, rd: 5'd9, data: 32'h0000_0099, exc: 1'b0});
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus_if.o_wb_valid !== 1'b1 || bus_if.o_exc !== 1'b0) begin
            failures++;
            $display("FAIL timeout_next_op got wbv=%b exc=%b, expected 1 0", bus_if.o_wb_valid, bus_if.o_exc);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd15, 1'b1);
        @(negedge clk);
        drive_idle();
        checks++;
        if (bus_if.o_dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre got req=%b, expected 1", bus_if.o_dmem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus_if.o_dmem_req !== 1'b0 || bus_if.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_async got req=%b ready=%b, expected 0 1", bus_if.o_dmem_req, bus_if.o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_if.i_dmem_ack   = 1'b1;
        bus_if.i_dmem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus_if.i_dmem_ack = 1'b0;
            checks++;
            if (bus_if.o_wb_valid !== 1'b0 || bus_if.o_dmem_req !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_after_%0d got wbv=%b req=%b, expected 0 0", c, bus_if.o_wb_valid, bus_if.o_dmem_req);
            end
        end
    endtask

    initial begin
        bus_if.i_dmem_ack   = 1'b0;
        bus_if.i_dmem_rdata = 32'd0;
        test_reset();
        test_alu_stream();
        test_store_byte();
        test_loads();
        test_exceptions();
        test_timeout();
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
